// File: rtl/uart_rx_byte.sv
// Purpose : 8N1 serial byte receiver (LSB first) with a level-held ready strobe and framing-error flag.
// Latency : omData/omData_Ready rise 1 cycle after the stop-bit centre sample (~9.5 bit times + 3 cycles after the start edge).
// Backpr. : none; the line cannot be stalled. A byte is offered as a READY_LEN-cycle strobe and bad frames are never forwarded.
//
// Ports:
//   iClk          system clock
//   iRst_n        asynchronous active-low reset
//   iRx           asynchronous serial line, idle high
//   omData        last good received byte, held until the next good byte
//   omData_Ready  high for READY_LEN cycles per good byte
//   oFrame_Err    one-cycle pulse when the stop bit samples low
//   oBusy         high while a frame is in progress (START, DATA, STOP, BREAK)

module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434,
  parameter int READY_LEN    = 16
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iRx,
  output logic [7:0] omData,
  output logic       omData_Ready,
  output logic       oFrame_Err,
  output logic       oBusy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int RW = $clog2(READY_LEN + 1);

  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [RW-1:0] R_LOAD = RW'(READY_LEN);
  localparam logic [RW-1:0] R_ONE  = RW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Synchronizer flops reset to 1 so a released reset on an idle line does
  // not look like a start edge.
  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q,    rx_s_d;

  state_t        state_q,   state_d;
  logic [TW-1:0] timer_q,   timer_d;
  logic [2:0]    idx_q,     idx_d;
  logic [7:0]    shift_q,   shift_d;
  logic [7:0]    data_q,    data_d;
  logic [RW-1:0] rdy_cnt_q, rdy_cnt_d;
  logic          frame_err_q, frame_err_d;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      rdy_cnt_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      rdy_cnt_q   <= rdy_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    rx_meta_d   = iRx;
    rx_s_d      = rx_meta_q;
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    frame_err_d = 1'b0;

    // The ready strobe is a free-running down-counter, independent of the
    // FSM. A reload can only come from a stop bit at least 9 bit times after
    // the previous one, so it never truncates a strobe still in flight.
    rdy_cnt_d = (rdy_cnt_q != '0) ? (rdy_cnt_q - R_ONE) : rdy_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          timer_d = '0;
        end
      end

      // Re-check the line at mid start bit to reject glitches; from here on
      // every sample lands on a bit centre.
      S_START: begin
        if (timer_q == T_HALF) begin
          timer_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            idx_d   = '0;
          end
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end

      S_DATA: begin
        if (timer_q == T_FULL) begin
          timer_d        = '0;
          shift_d[idx_q] = rx_s_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end

      // Returning to IDLE at mid stop bit leaves half a bit of margin to
      // catch a back-to-back start edge.
      S_STOP: begin
        if (timer_q == T_FULL) begin
          timer_d = '0;
          if (rx_s_q) begin
            data_d    = shift_q;
            rdy_cnt_d = R_LOAD;
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end

      // Line held low past the stop bit (break or framing error): wait for
      // idle before hunting for the next start edge.
      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign omData       = data_q;
  assign omData_Ready = (rdy_cnt_q != '0);
  assign oFrame_Err   = frame_err_q;
  assign oBusy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Purpose : bench for uart_rx_byte at CLKS_PER_BIT=8, READY_LEN=4.
// Latency : expected byte latency is 9.5 bit times + 3 cycles from the start edge.
// Backpr. : none; the bench only observes strobes.

module tb_uart_rx_byte;

  localparam int CPB = 8;
  localparam int RL  = 4;
  localparam int LAT = 9 * CPB + CPB / 2 + 3;

  logic       iClk   = 1'b0;
  logic       iRst_n = 1'b0;
  logic       iRx    = 1'b1;
  logic [7:0] omData;
  logic       omData_Ready;
  logic       oFrame_Err;
  logic       oBusy;

  uart_rx_byte #(.CLKS_PER_BIT(CPB), .READY_LEN(RL)) dut (
    .iClk         (iClk),
    .iRst_n       (iRst_n),
    .iRx          (iRx),
    .omData       (omData),
    .omData_Ready (omData_Ready),
    .oFrame_Err   (oFrame_Err),
    .oBusy        (oBusy)
  );

  always #5 iClk = ~iClk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;

  always @(posedge iClk) cyc <= cyc + 1;

  // Reference model: one expected byte per frame sent with a good stop bit,
  // one expected error pulse per frame sent with a bad stop bit.
  logic [7:0] exp_q[$];
  int         exp_err = 0;

  // Observations of the DUT outputs.
  logic [7:0] got_q[$];
  int         len_q[$];
  int         rise_q[$];
  int         err_cycles = 0;
  int         bad_change = 0;
  logic       mon_prev_rdy = 1'b0;
  logic [7:0] mon_prev_data = 8'h00;
  int         run_len = 0;

  always @(negedge iClk) begin
    if (!iRst_n) begin
      mon_prev_rdy  = 1'b0;
      mon_prev_data = omData;
      run_len       = 0;
    end else begin
      if (omData_Ready && !mon_prev_rdy) begin
        got_q.push_back(omData);
        rise_q.push_back(cyc);
        run_len = 1;
      end else if (omData_Ready) begin
        run_len++;
      end
      if (!omData_Ready && mon_prev_rdy) len_q.push_back(run_len);
      // omData may only change together with a fresh ready rising edge.
      if (omData !== mon_prev_data && !(omData_Ready && !mon_prev_rdy)) bad_change++;
      if (oFrame_Err) err_cycles++;
      mon_prev_rdy  = omData_Ready;
      mon_prev_data = omData;
    end
  end

  // Command decoder: rising edge captures, falling edge advances. Opcode 0x01
  // followed by a 32-bit code sent least significant byte first.
  logic        dec_clear = 1'b0;
  logic        dec_prev  = 1'b0;
  logic [7:0]  dec_cap   = 8'h00;
  int          dec_cnt   = 0;
  logic [31:0] dec_code  = 32'h0;
  logic        dec_ready = 1'b0;

  always @(negedge iClk) begin
    if (dec_clear || !iRst_n) begin
      dec_cnt   = 0;
      dec_code  = 32'h0;
      dec_ready = 1'b0;
    end else begin
      if (omData_Ready && !dec_prev) dec_cap = omData;
      if (!omData_Ready && dec_prev) begin
        if (dec_cnt == 0) begin
          if (dec_cap == 8'h01) begin
            dec_cnt   = 1;
            dec_ready = 1'b0;
          end
        end else begin
          dec_code = {dec_cap, dec_code[31:8]};
          dec_cnt++;
          if (dec_cnt == 5) begin
            dec_ready = 1'b1;
            dec_cnt   = 0;
          end
        end
      end
    end
    dec_prev = omData_Ready;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic line_idle(input int n);
    iRx = 1'b1;
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, output int t0);
    t0  = cyc;
    iRx = 1'b0;
    repeat (CPB) @(posedge iClk);
    #1;
    for (int i = 0; i < 8; i++) begin
      iRx = b[i];
      repeat (CPB) @(posedge iClk);
      #1;
    end
    iRx = stop_v;
    repeat (CPB) @(posedge iClk);
    #1;
    if (stop_v) exp_q.push_back(b);
    else exp_err++;
  endtask

  task automatic test_reset();
    iRst_n = 1'b0;
    iRx    = 1'b1;
    repeat (3) @(posedge iClk);
    #1;
    chk_cnt++; if (omData !== 8'h00) $display("FAIL reset_data: got %h want 00", omData); else pass_cnt++;
    chk_cnt++; if (omData_Ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", omData_Ready); else pass_cnt++;
    chk_cnt++; if (oFrame_Err !== 1'b0) $display("FAIL reset_err: got %b want 0", oFrame_Err); else pass_cnt++;
    chk_cnt++; if (oBusy !== 1'b0) $display("FAIL reset_busy: got %b want 0", oBusy); else pass_cnt++;
    iRst_n = 1'b1;
    line_idle(5);
  endtask

  task automatic test_single();
    int gb, lb, eb, e0, t0;
    gb = got_q.size(); lb = len_q.size(); eb = exp_q.size(); e0 = err_cycles;
    send_frame(8'h01, 1'b1, t0);
    line_idle(RL + CPB);
    chk_cnt++; if (got_q.size() !== gb + 1) $display("FAIL single_count: got %0d want %0d", got_q.size() - gb, 1); else pass_cnt++;
    chk_cnt++; if (got_q[gb] !== exp_q[eb]) $display("FAIL single_data: got %h want %h", got_q[gb], exp_q[eb]); else pass_cnt++;
    chk_cnt++; if (len_q[lb] !== RL) $display("FAIL single_len: got %0d want %0d", len_q[lb], RL); else pass_cnt++;
    chk_cnt++; if (rise_q[gb] - t0 !== LAT) $display("FAIL single_latency: got %0d want %0d", rise_q[gb] - t0, LAT); else pass_cnt++;
    chk_cnt++; if (err_cycles !== e0) $display("FAIL single_err: got %0d want %0d", err_cycles - e0, 0); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int gb, lb, eb, bc, t0;
    gb = got_q.size(); lb = len_q.size(); eb = exp_q.size(); bc = bad_change;
    send_frame(8'hA5, 1'b1, t0);
    send_frame(8'h3C, 1'b1, t0);
    line_idle(RL + CPB);
    chk_cnt++; if (got_q.size() !== gb + 2) $display("FAIL b2b_count: got %0d want 2", got_q.size() - gb); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      chk_cnt++; if (got_q[gb+i] !== exp_q[eb+i]) $display("FAIL b2b_data%0d: got %h want %h", i, got_q[gb+i], exp_q[eb+i]); else pass_cnt++;
      chk_cnt++; if (len_q[lb+i] !== RL) $display("FAIL b2b_len%0d: got %0d want %0d", i, len_q[lb+i], RL); else pass_cnt++;
    end
    chk_cnt++; if (rise_q[gb+1] - rise_q[gb] !== 10 * CPB) $display("FAIL b2b_spacing: got %0d want %0d", rise_q[gb+1] - rise_q[gb], 10 * CPB); else pass_cnt++;
    chk_cnt++; if (bad_change !== bc) $display("FAIL b2b_stable: got %0d stray changes want 0", bad_change - bc); else pass_cnt++;
  endtask

  task automatic test_false_start();
    int gb, e0;
    logic seen_busy;
    gb = got_q.size(); e0 = err_cycles; seen_busy = 1'b0;
    iRx = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    iRx = 1'b1;
    repeat (CPB / 2 + 3) begin
      @(posedge iClk);
      #1;
      if (oBusy) seen_busy = 1'b1;
    end
    chk_cnt++; if (seen_busy !== 1'b1) $display("FAIL false_start_busy_seen: got %b want 1", seen_busy); else pass_cnt++;
    chk_cnt++; if (oBusy !== 1'b0) $display("FAIL false_start_busy_clear: got %b want 0", oBusy); else pass_cnt++;
    line_idle(2 * CPB);
    chk_cnt++; if (got_q.size() !== gb) $display("FAIL false_start_ready: got %0d strobes want 0", got_q.size() - gb); else pass_cnt++;
    chk_cnt++; if (err_cycles !== e0) $display("FAIL false_start_err: got %0d want 0", err_cycles - e0); else pass_cnt++;
  endtask

  task automatic test_frame_error();
    int gb, e0, ee, t0;
    gb = got_q.size(); e0 = err_cycles; ee = exp_err;
    send_frame(8'h55, 1'b0, t0);
    iRx = 1'b0;
    repeat (40) @(posedge iClk);
    #1;
    chk_cnt++; if (oBusy !== 1'b1) $display("FAIL ferr_busy_break: got %b want 1", oBusy); else pass_cnt++;
    chk_cnt++; if (err_cycles - e0 !== exp_err - ee) $display("FAIL ferr_pulse: got %0d cycles want %0d", err_cycles - e0, exp_err - ee); else pass_cnt++;
    chk_cnt++; if (omData !== exp_q[exp_q.size()-1]) $display("FAIL ferr_data_held: got %h want %h", omData, exp_q[exp_q.size()-1]); else pass_cnt++;
    chk_cnt++; if (got_q.size() !== gb) $display("FAIL ferr_no_ready: got %0d strobes want 0", got_q.size() - gb); else pass_cnt++;
    line_idle(4);
    send_frame(8'h7E, 1'b1, t0);
    line_idle(RL + CPB);
    chk_cnt++; if (got_q.size() !== gb + 1) $display("FAIL ferr_recover_count: got %0d want 1", got_q.size() - gb); else pass_cnt++;
    chk_cnt++; if (got_q[gb] !== exp_q[exp_q.size()-1]) $display("FAIL ferr_recover_data: got %h want %h", got_q[gb], exp_q[exp_q.size()-1]); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    int gb, e0, t0;
    logic [7:0] b;
    b = 8'hFF;
    iRx = 1'b0;
    repeat (CPB) @(posedge iClk);
    #1;
    for (int i = 0; i < 4; i++) begin
      iRx = b[i];
      repeat (CPB) @(posedge iClk);
      #1;
    end
    iRx = b[4];
    repeat (CPB / 2) @(posedge iClk);
    #1;
    iRst_n = 1'b0;
    #1;
    chk_cnt++; if (omData !== 8'h00) $display("FAIL midrst_data: got %h want 00", omData); else pass_cnt++;
    chk_cnt++; if (omData_Ready !== 1'b0) $display("FAIL midrst_ready: got %b want 0", omData_Ready); else pass_cnt++;
    chk_cnt++; if (oBusy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", oBusy); else pass_cnt++;
    repeat (2) @(posedge iClk);
    #1;
    iRst_n = 1'b1;
    gb = got_q.size(); e0 = err_cycles;
    line_idle(3 * CPB);
    chk_cnt++; if (got_q.size() !== gb || err_cycles !== e0) $display("FAIL midrst_no_pulse: got %0d strobes %0d err want 0 0", got_q.size() - gb, err_cycles - e0); else pass_cnt++;
    send_frame(8'h02, 1'b1, t0);
    line_idle(RL + CPB);
    chk_cnt++; if (got_q[gb] !== exp_q[exp_q.size()-1]) $display("FAIL midrst_next_data: got %h want %h", got_q[gb], exp_q[exp_q.size()-1]); else pass_cnt++;
  endtask

  task automatic test_cmd_stream();
    int gb, eb, t0;
    logic [7:0] cmd [5];
    cmd[0] = 8'h01; cmd[1] = 8'h78; cmd[2] = 8'h56; cmd[3] = 8'h34; cmd[4] = 8'h12;
    @(posedge iClk); #1;
    dec_clear = 1'b1;
    @(posedge iClk); #1;
    dec_clear = 1'b0;
    gb = got_q.size(); eb = exp_q.size();
    for (int i = 0; i < 5; i++) send_frame(cmd[i], 1'b1, t0);
    line_idle(RL + CPB);
    chk_cnt++; if (got_q.size() !== gb + 5) $display("FAIL cmd_count: got %0d want 5", got_q.size() - gb); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      chk_cnt++; if (got_q[gb+i] !== exp_q[eb+i]) $display("FAIL cmd_data%0d: got %h want %h", i, got_q[gb+i], exp_q[eb+i]); else pass_cnt++;
    end
    chk_cnt++; if (dec_ready !== 1'b1) $display("FAIL cmd_dec_ready: got %b want 1", dec_ready); else pass_cnt++;
    chk_cnt++; if (dec_code !== 32'h12345678) $display("FAIL cmd_dec_code: got %h want 12345678", dec_code); else pass_cnt++;
  endtask

  task automatic test_random();
    int gb, lb, eb, e0, ee, bc, t0;
    logic [7:0] b;
    logic bad;
    gb = got_q.size(); lb = len_q.size(); eb = exp_q.size();
    e0 = err_cycles; ee = exp_err; bc = bad_change;
    for (int n = 0; n < 16; n++) begin
      b   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 3) == 0);
      send_frame(b, !bad, t0);
      if (bad) begin
        iRx = 1'b0;
        repeat ($urandom_range(0, 30)) @(posedge iClk);
        #1;
        line_idle($urandom_range(2, 10));
      end else begin
        line_idle($urandom_range(0, 12));
      end
    end
    line_idle(RL + 2 * CPB);
    chk_cnt++; if (got_q.size() - gb !== exp_q.size() - eb) $display("FAIL rand_count: got %0d want %0d", got_q.size() - gb, exp_q.size() - eb); else pass_cnt++;
    for (int i = 0; i < exp_q.size() - eb; i++) begin
      chk_cnt++; if (got_q[gb+i] !== exp_q[eb+i]) $display("FAIL rand_data%0d: got %h want %h", i, got_q[gb+i], exp_q[eb+i]); else pass_cnt++;
      chk_cnt++; if (len_q[lb+i] !== RL) $display("FAIL rand_len%0d: got %0d want %0d", i, len_q[lb+i], RL); else pass_cnt++;
    end
    chk_cnt++; if (err_cycles - e0 !== exp_err - ee) $display("FAIL rand_err: got %0d want %0d", err_cycles - e0, exp_err - ee); else pass_cnt++;
    chk_cnt++; if (bad_change !== bc) $display("FAIL rand_stable: got %0d stray changes want 0", bad_change - bc); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_error();
    test_reset_mid_frame();
    test_cmd_stream();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
Serial byte receiver feeding the host command decoder. It samples the asynchronous RX line (8N1, LSB first) and presents each received byte on omData, with a level-held ready strobe omData_Ready. The strobe's rising edge captures the byte and its falling edge advances decoder state, so data must stay stable for the whole strobe and beyond. Framing errors are flagged and never forwarded as data.

Parameters:
CLKS_PER_BIT, 434, iClk cycles per bit (50 MHz / 115200); minimum 8.
READY_LEN, 16, cycles omData_Ready is held high per byte; must satisfy 2 <= READY_LEN < 9*CLKS_PER_BIT.

Ports:
iClk  input  1  system clock
iRst_n  input  1  asynchronous active-low reset
iRx  input  1  asynchronous serial line, idle high
omData  output  8  last good received byte
omData_Ready  output  1  high for READY_LEN cycles per good byte
oFrame_Err  output  1  one-cycle pulse on bad stop bit
oBusy  output  1  high while a frame is in progress (START, DATA, STOP, BREAK)

Behaviour:
- Reset (iRst_n low, async): omData=0x00, omData_Ready=0, oFrame_Err=0, oBusy=0, state=IDLE, counters=0, synchronizer flops=1.
- iRx passes through a 2-flop synchronizer. All decisions use the synchronized value rx_s.
- State IDLE: on rx_s==0, go to START and clear the bit-timer.
- State START: at timer==CLKS_PER_BIT/2-1 (mid start bit):
  - rx_s==1: false start; go to IDLE, no outputs.
  - rx_s==0: go to DATA, bit index=0, timer=0.
- State DATA: sample rx_s into shift-reg bit[index] at each timer==CLKS_PER_BIT-1 (bit centres), LSB first. After bit 7, go to STOP.
- State STOP: sample at the next bit centre.
  - rx_s==1: next cycle, omData<=shift-reg and omData_Ready<=1 (ready counter loaded with READY_LEN); state=IDLE. Returning at mid stop bit allows back-to-back frames.
  - rx_s==0: oFrame_Err pulses one cycle; omData and omData_Ready are unchanged; go to BREAK.
- State BREAK: wait for rx_s==1, then go to IDLE.
- Ready counter runs independently of the FSM; omData_Ready deasserts after exactly READY_LEN cycles.
- omData is held until the next good byte's stop-bit sample. It is never modified while omData_Ready is high; the parameter constraint guarantees this.
- Latency: omData/omData_Ready rise 1 cycle after the stop-bit centre sample, which is about 9.5 bit times plus 3 cycles after the start edge on iRx.
- Timer and index widths: $clog2(CLKS_PER_BIT) and 3 bits; no wrap beyond the stated compare values.
- Async reset mid-frame aborts the frame immediately, with no ready or error pulse. After release, reception waits for a fresh falling edge; a line already low at release is treated as a start edge.

Test Plan:
- CLKS_PER_BIT=8, READY_LEN=4; send 0x01 -> omData=0x01, omData_Ready high exactly 4 cycles, oFrame_Err stays 0.
- Back-to-back 0xA5 then 0x3C with no idle gap -> two ready strobes; omData 0xA5 then 0x3C; 0xA5 stable throughout its strobe.
- iRx low for 2 cycles then high -> no ready, no error, oBusy returns to 0 within CLKS_PER_BIT/2+3 cycles.
- Send 0x55 with stop bit 0, hold iRx low 40 cycles, then send 0x7E -> one oFrame_Err pulse; omData keeps its previous value; then 0x7E is received correctly.
- Assert iRst_n low during DATA bit 4 of 0xFF -> outputs reset immediately; next frame 0x02 is received correctly.
- Command stream 0x01,0x78,0x56,0x34,0x12 -> five ready strobes; a connected command decoder reports code 0x12345678 as ready.
